// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller:
// op encodings, FSM state encoding, default latencies and op classifiers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } mdOp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mduState_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic isMulticycle(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit product, quotient/remainder and
// divide-by-zero flag for the currently pending operands.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        isSigned,
  output logic [63:0] product,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        divZero
);

  logic [63:0] extA;
  logic [63:0] extB;
  logic        negA;
  logic        negB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] divisor;
  logic [31:0] uQuo;
  logic [31:0] uRem;

  // Sign/zero-extend to 64 bits so one truncated multiply serves both
  // signed and unsigned; division works on magnitudes and fixes signs after,
  // which also keeps INT_MIN / -1 well defined (wraps to INT_MIN).
  always_comb begin
    extA      = isSigned ? {{32{opA[31]}}, opA} : {32'd0, opA};
    extB      = isSigned ? {{32{opB[31]}}, opB} : {32'd0, opB};
    product   = extA * extB;

    negA      = isSigned & opA[31];
    negB      = isSigned & opB[31];
    magA      = negA ? (32'd0 - opA) : opA;
    magB      = negB ? (32'd0 - opB) : opB;
    divZero   = (opB == 32'd0);
    divisor   = divZero ? 32'd1 : magB;
    uQuo      = magA / divisor;
    uRem      = magA % divisor;
    quotient  = (negA ^ negB) ? (32'd0 - uQuo) : uQuo;
    remainder = negA ? (32'd0 - uRem) : uRem;
  end

endmodule

// File: rtl/mdu_controller.sv
// MDU controller: accepts E-stage MDU ops, sequences the multi-cycle
// busy period, owns HI/LO and generates the D-stage stall request.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no op in flight; MT*/MF* complete immediately, mult/div accepted
//   BUSY  | mult/div in flight; counter counts down, commit when it hits 1
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        exc_cancel,
  input  logic        d_md_use,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  mduState_t   state;
  logic [CW-1:0] count;
  logic [31:0] pendA;
  logic [31:0] pendB;
  logic [2:0]  pendOp;
  logic        accept;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divZero;

  assign accept = start & ~exc_cancel & ~busy;

  // Results are computed from the operands latched at acceptance, so the
  // forwarded sources are free to change while the op is in flight.
  mdu_arith uArith (
    .opA      (pendA),
    .opB      (pendB),
    .isSigned (isSignedOp(pendOp)),
    .product  (product),
    .quotient (quotient),
    .remainder(remainder),
    .divZero  (divZero)
  );

  // FSM, down-counter, pending operands and HI/LO; busy is registered with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      pendA  <= '0;
      pendB  <= '0;
      pendOp <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                pendA  <= src_a;
                pendB  <= src_b;
                pendOp <= md_op;
                count  <= CW'(MULT_CYCLES);
                busy   <= 1'b1;
                state  <= BUSY;
              end
              MD_DIV, MD_DIVU: begin
                pendA  <= src_a;
                pendB  <= src_b;
                pendOp <= md_op;
                count  <= CW'(DIV_CYCLES);
                busy   <= 1'b1;
                state  <= BUSY;
              end
              MD_MTHI: hi <= src_a;
              MD_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          // exc_cancel is deliberately ignored here: an op already in flight
          // always completes and commits.
          if (count == CW'(1)) begin
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
            if (isDivOp(pendOp)) begin
              // Divide by zero leaves HI/LO untouched after the full latency.
              if (!divZero) begin
                hi <= remainder;
                lo <= quotient;
              end
            end else begin
              hi <= product[63:32];
              lo <= product[31:0];
            end
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

  assign stall_req = d_md_use & (busy | (start & ~exc_cancel & isMulticycle(md_op)));
  assign rdata     = (md_op == MD_MFHI) ? hi : lo;

endmodule

// File: tb/tb_mdu_controller.sv
// Self-checking bench for mdu_controller using a result scoreboard.
module tb_mdu_controller;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic        exc_cancel;
  logic        d_md_use;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] expQ[$];

  mdu_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .exc_cancel(exc_cancel),
    .d_md_use  (d_md_use),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

  // Drive one op for a single cycle, then scramble the sources after acceptance.
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cancel);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; src_a = a; src_b = b; exc_cancel = cancel;
    @(posedge clk); #1;
    start = 1'b0; exc_cancel = 1'b0; md_op = MD_MFLO;
    src_a = $urandom; src_b = $urandom;
  endtask

  // Count busy cycles, then pop the expected {hi,lo} and compare.
  task automatic wait_done(input int expN, input string name);
    int n;
    logic [63:0] exp;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== expN) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, expN);
    end
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      exp = expQ.pop_front();
      if ({hi, lo} !== exp) begin
        miscompares++;
        $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; md_op = MD_MFLO; exc_cancel = 1'b0; d_md_use = 1'b0;
    src_a = '0; src_b = '0;
    #23;
    vectors++;
    if ({busy, stall_req, hi, lo, rdata} !== 98'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b stall=%b hi=%h lo=%h rdata=%h expected all zero",
               busy, stall_req, hi, lo, rdata);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mult();
    expQ.push_back(64'hFFFFFFFF_FFFFFFFE);
    drive_op(MD_MULT, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    wait_done(5, "mult");
  endtask

  task automatic test_multu();
    expQ.push_back(64'h00000001_FFFFFFFE);
    drive_op(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    wait_done(5, "multu");
  endtask

  task automatic test_div_stall();
    int n;
    logic [63:0] exp;
    expQ.push_back(64'hFFFFFFFF_FFFFFFFD);
    d_md_use = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_DIV; src_a = 32'hFFFFFFF9; src_b = 32'h00000002;
    #1;
    vectors++;
    if (stall_req !== 1'b1) begin
      miscompares++;
      $display("FAIL div_stall_issue: got %b expected 1", stall_req);
    end
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_MFLO; src_a = $urandom; src_b = $urandom;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      vectors++;
      if (stall_req !== 1'b1) begin
        miscompares++;
        $display("FAIL div_stall_busy cycle %0d: got %b expected 1", n, stall_req);
      end
      @(negedge clk);
    end
    vectors++;
    if (n !== 10) begin
      miscompares++;
      $display("FAIL div busy_cycles: got %0d expected 10", n);
    end
    vectors++;
    if (stall_req !== 1'b0) begin
      miscompares++;
      $display("FAIL div_stall_after: got %b expected 0", stall_req);
    end
    exp = expQ.pop_front();
    vectors++;
    if ({hi, lo} !== exp) begin
      miscompares++;
      $display("FAIL div hilo: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
    end
    d_md_use = 1'b0;
  endtask

  task automatic test_divu_zero();
    drive_op(MD_MTHI, 32'h00001234, 32'h0, 1'b0);
    drive_op(MD_MTLO, 32'h00005678, 32'h0, 1'b0);
    expQ.push_back(64'h00001234_00005678);
    drive_op(MD_DIVU, 32'h0000DEAD, 32'h0, 1'b0);
    wait_done(10, "divu_zero");
  endtask

  task automatic test_cancel();
    int sawBusy;
    drive_op(MD_MTHI, 32'h00000055, 32'h0, 1'b0);
    drive_op(MD_MULT, 32'h00000003, 32'h00000004, 1'b1);
    sawBusy = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) sawBusy++;
    end
    vectors++;
    if (sawBusy != 0 || hi !== 32'h55 || lo !== 32'h5678) begin
      miscompares++;
      $display("FAIL cancel_mult: got busy_cycles=%0d hi=%h lo=%h expected 0 55 5678", sawBusy, hi, lo);
    end
    drive_op(MD_MTHI, 32'h0000ABCD, 32'h0, 1'b1);
    vectors++;
    if (hi !== 32'h55) begin
      miscompares++;
      $display("FAIL cancel_mthi: got hi=%h expected 00000055", hi);
    end
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MTHI; src_a = 32'h0000ABCD;
    @(negedge clk);
    vectors++;
    if (hi !== 32'h55) begin
      miscompares++;
      $display("FAIL mthi_before_edge: got hi=%h expected 00000055", hi);
    end
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_MFLO;
    vectors++;
    if (hi !== 32'hABCD || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi_commit: got hi=%h busy=%b expected 0000abcd 0", hi, busy);
    end
  endtask

  task automatic test_rdata();
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MFHI; src_a = 32'hFFFF0000;
    #1;
    vectors++;
    if (rdata !== 32'hABCD) begin
      miscompares++;
      $display("FAIL rdata_mfhi: got %h expected 0000abcd", rdata);
    end
    @(posedge clk); #1;
    md_op = MD_MFLO;
    #1;
    vectors++;
    if (rdata !== 32'h5678 || hi !== 32'hABCD || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rdata_mflo: got rdata=%h hi=%h busy=%b expected 00005678 0000abcd 0", rdata, hi, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_ignore_while_busy();
    expQ.push_back(64'h00000000_0000002A);
    drive_op(MD_MULT, 32'h7, 32'h6, 1'b0);
    start = 1'b1; md_op = MD_MTLO; src_a = 32'h00009999;
    @(posedge clk); #1;
    vectors++;
    if (lo !== 32'h5678 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_mtlo: got lo=%h busy=%b expected 00005678 1", lo, busy);
    end
    md_op = MD_DIVU; src_a = 32'h100; src_b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_MFLO;
    wait_done(3, "ignore_busy");
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int sa;
    int sb;
    for (int k = 0; k < 8; k++) begin
      op = 3'(k % 4);
      a = $urandom;
      b = $urandom;
      if (k == 2) begin a = 32'hFFFFFF85; b = 32'h00000007; end
      if (a == 32'h80000000) a = 32'h7FFFFFFF;
      if (b == 32'h0) b = 32'h3;
      if ((op == MD_DIV || op == MD_DIVU) && (k % 3 == 0)) b = b >> 20;
      if (b == 32'h0) b = 32'h5;
      sa = a;
      sb = b;
      case (op)
        MD_MULT:  exp = longint'(sa) * longint'(sb);
        MD_MULTU: exp = {32'd0, a} * {32'd0, b};
        MD_DIV:   exp = {32'(sa % sb), 32'(sa / sb)};
        default:  exp = {a % b, a / b};
      endcase
      expQ.push_back(exp);
      drive_op(op, a, b, 1'b0);
      wait_done((op == MD_DIV || op == MD_DIVU) ? 10 : 5, "back_to_back");
    end
  endtask

  task automatic test_async_reset();
    int bad;
    drive_op(MD_MTHI, 32'h1111, 32'h0, 1'b0);
    drive_op(MD_MTLO, 32'h2222, 32'h0, 1'b0);
    drive_op(MD_MULT, 32'h100, 32'h100, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL no_commit_after_reset: got %0d bad cycles hi=%h lo=%h expected 0", bad, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div_stall();
    test_divu_zero();
    test_cancel();
    test_rdata();
    test_ignore_while_busy();
    test_back_to_back();
    test_async_reset();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
